// File: rtl/scan_dac_writer_pkg.sv
// Shared definitions for the scan DAC writer: frame geometry, sequencer states
// and the AD5662-style command prefixes.
package scan_dac_writer_pkg;

    localparam int FRAME_BITS = 24;
    localparam int DATA_BITS  = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        LDAC
    } state_t;

    // Power-down bits sit in the low two bits of the command byte.
    localparam logic [7:0] CMD_NORMAL   = 8'h00;
    localparam logic [7:0] CMD_PD_1K    = 8'h01;
    localparam logic [7:0] CMD_PD_100K  = 8'h02;
    localparam logic [7:0] CMD_TRISTATE = 8'h03;

endpackage

// File: rtl/scan_dac_writer_dac_frame_shifter.sv
// SPI frame engine: holds SYNC low for a setup half-period, then clocks out
// FRAME_BITS MSB first so the DAC can sample on each falling SCLK edge.
module dac_frame_shifter
    import scan_dac_writer_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  sinit,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  setup_end,
    output logic                  frame_end,
    output logic                  sclk,
    output logic                  din,
    output logic                  sync_n
);

    localparam logic [7:0] HALF_LOAD = 8'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LOAD  = 5'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] shreg;
    logic [4:0]            bit_cnt;
    logic [7:0]            half_cnt;
    logic                  active;
    logic                  in_setup;
    logic                  half_tc;

    assign half_tc   = (half_cnt == 8'd0);
    assign setup_end = active & in_setup & half_tc;
    assign frame_end = active & ~in_setup & ~sclk & half_tc & (bit_cnt == 5'd0);

    always_ff @(posedge clk) begin
        if (sinit) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            half_cnt <= '0;
            active   <= 1'b0;
            in_setup <= 1'b0;
            sclk     <= 1'b0;
            din      <= 1'b0;
            sync_n   <= 1'b1;
        end else if (start) begin
            shreg    <= frame;
            din      <= frame[FRAME_BITS-1];
            sync_n   <= 1'b0;
            bit_cnt  <= BIT_LOAD;
            half_cnt <= HALF_LOAD;
            active   <= 1'b1;
            in_setup <= 1'b1;
        end else if (active) begin
            if (!half_tc) begin
                half_cnt <= half_cnt - 8'd1;
            end else begin
                half_cnt <= HALF_LOAD;
                if (in_setup) begin
                    in_setup <= 1'b0;
                    sclk     <= 1'b1;
                end else if (sclk) begin
                    sclk <= 1'b0;
                end else if (bit_cnt == 5'd0) begin
                    sync_n <= 1'b1;
                    din    <= 1'b0;
                    active <= 1'b0;
                end else begin
                    // End of the low half: the DAC has already sampled, so advance.
                    shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                    din     <= shreg[FRAME_BITS-2];
                    bit_cnt <= bit_cnt - 5'd1;
                    sclk    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/scan_dac_writer.sv
// Accepts scan/host updates into a one-deep pending slot, sends each as an SPI
// frame to the DAC, pulses LDAC and reports the last value written.
//
//  state | meaning
//  IDLE  | waiting for a pending value; loads the frame when one is present
//  SETUP | SYNC low, SCLK low for one half-period before the first bit
//  SHIFT | clocking out the 24 frame bits
//  LDAC  | LDAC held low, then done pulse and readback update
module scan_dac_writer
    import scan_dac_writer_pkg::*;
#(
    parameter int         CLK_DIV    = 4,
    parameter int         LDAC_WIDTH = 2,
    parameter logic [7:0] CMD_BYTE   = CMD_NORMAL
) (
    input  logic        clk,
    input  logic        sinit,
    input  logic        enable,
    input  logic [15:0] scan_data,
    input  logic        scan_upd,
    input  logic [15:0] host_data,
    input  logic        host_wr,
    output logic        dac_sclk,
    output logic        dac_din,
    output logic        dac_sync_n,
    output logic        dac_ldac_n,
    output logic        busy,
    output logic        done,
    output logic [15:0] last_written,
    output logic [15:0] drop_count
);

    state_t                 state;
    state_t                 state_next;
    logic                   start;
    logic                   ldac_fin;
    logic                   setup_end;
    logic                   frame_end;
    logic                   pend_valid;
    logic [DATA_BITS-1:0]   pend_data;
    logic [DATA_BITS-1:0]   frame_data;
    logic [3:0]             ldac_cnt;
    logic                   cap_host;
    logic                   cap_scan;
    logic                   capture;
    logic                   drop_inc;

    assign cap_host = host_wr;
    assign cap_scan = scan_upd & enable;
    assign capture  = cap_host | cap_scan;
    // A collision loses the scan value; an overwrite loses the pending one. Either costs one count.
    assign drop_inc = (cap_host & cap_scan) | (capture & pend_valid & ~start);

    always_comb begin
        state_next = state;
        start      = 1'b0;
        ldac_fin   = 1'b0;
        case (state)
            IDLE: begin
                if (pend_valid) begin
                    start      = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: if (setup_end) state_next = SHIFT;
            SHIFT: if (frame_end) state_next = LDAC;
            LDAC: begin
                if (ldac_cnt == 4'd0) begin
                    ldac_fin   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sinit) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (sinit) begin
            pend_valid   <= 1'b0;
            pend_data    <= '0;
            frame_data   <= '0;
            ldac_cnt     <= '0;
            dac_ldac_n   <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            last_written <= '0;
            drop_count   <= '0;
        end else begin
            done <= ldac_fin;
            if (capture) begin
                pend_valid <= 1'b1;
                pend_data  <= cap_host ? host_data : scan_data;
            end else if (start) begin
                pend_valid <= 1'b0;
            end
            if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            if (start) begin
                frame_data <= pend_data;
                busy       <= 1'b1;
            end
            if (frame_end) ldac_cnt <= 4'(LDAC_WIDTH);
            if (state == LDAC) begin
                if (ldac_cnt != 4'd0) begin
                    dac_ldac_n <= 1'b0;
                    ldac_cnt   <= ldac_cnt - 4'd1;
                end else begin
                    dac_ldac_n   <= 1'b1;
                    busy         <= 1'b0;
                    last_written <= frame_data;
                end
            end
        end
    end

    dac_frame_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk      (clk),
        .sinit    (sinit),
        .start    (start),
        .frame    ({CMD_BYTE, pend_data}),
        .setup_end(setup_end),
        .frame_end(frame_end),
        .sclk     (dac_sclk),
        .din      (dac_din),
        .sync_n   (dac_sync_n)
    );

endmodule

// File: tb/tb_scan_dac_writer.sv
// Bench for scan_dac_writer: decodes SPI frames off the pins and checks
// them against directed vectors and a few multi-cycle sequences.
module tb_scan_dac_writer;

    localparam int CD      = 2;
    localparam int LW      = 2;
    localparam int SPACING = 49 * CD + LW + 2;

    logic        clk = 1'b0;
    logic        sinit = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] scan_data = '0;
    logic        scan_upd = 1'b0;
    logic [15:0] host_data = '0;
    logic        host_wr = 1'b0;
    logic        dac_sclk, dac_din, dac_sync_n, dac_ldac_n, busy, done;
    logic [15:0] last_written, drop_count;

    scan_dac_writer #(.CLK_DIV(CD), .LDAC_WIDTH(LW), .CMD_BYTE(8'h00)) dut (
        .clk(clk), .sinit(sinit), .enable(enable),
        .scan_data(scan_data), .scan_upd(scan_upd),
        .host_data(host_data), .host_wr(host_wr),
        .dac_sclk(dac_sclk), .dac_din(dac_din), .dac_sync_n(dac_sync_n),
        .dac_ldac_n(dac_ldac_n), .busy(busy), .done(done),
        .last_written(last_written), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pin-level monitor, sampled on the falling clk edge.
    logic        prev_sclk = 1'b0, prev_sync = 1'b1, prev_ldac = 1'b1;
    logic [23:0] shbits = '0;
    int          nbits = 0, slen = 0, llen = 0, done_cnt = 0;
    logic [23:0] fr_data[$];
    int          fr_bits[$], fr_len[$], starts[$], ldac_lens[$];

    always @(negedge clk) begin
        if (prev_sync && !dac_sync_n) begin
            starts.push_back(cyc);
            nbits = 0; slen = 0; shbits = '0;
        end
        if (!dac_sync_n) begin
            slen++;
            if (prev_sclk && !dac_sclk) begin
                shbits = {shbits[22:0], dac_din};
                nbits++;
            end
        end
        if (!prev_sync && dac_sync_n) begin
            fr_data.push_back(shbits); fr_bits.push_back(nbits); fr_len.push_back(slen);
        end
        if (prev_ldac && !dac_ldac_n) llen = 0;
        if (!dac_ldac_n) llen++;
        if (!prev_ldac && dac_ldac_n) ldac_lens.push_back(llen);
        if (done) done_cnt++;
        prev_sclk = dac_sclk; prev_sync = dac_sync_n; prev_ldac = dac_ldac_n;
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        fr_data.delete(); fr_bits.delete(); fr_len.delete();
        starts.delete(); ldac_lens.delete(); done_cnt = 0;
    endtask

    task automatic do_reset();
        sinit = 1'b1; tick(); sinit = 1'b0;
        clear_mon();
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cnt < n && k < budget) begin tick(); k++; end
        chk("done_reached", 32'(done_cnt >= n), 32'd1);
    endtask

    typedef struct {
        logic        hw, su, en;
        logic [15:0] hd, sd;
        logic        exp_frame;
        logic [15:0] exp_data, exp_drop;
    } vec_t;

    vec_t vecs[7];
    int   t_strobe, n_before, d_before, bad_sp, k;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'hA5C3, 1'b1, 16'hA5C3, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h0001, 1'b1, 16'hBEEF, 16'd1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0, 16'h0000, 16'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h5678, 16'h0000, 1'b1, 16'h5678, 16'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 16'd0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h8001, 1'b1, 16'h8001, 16'd0};

        repeat (2) tick();
        do_reset();
        chk("rst_sync_n", 32'(dac_sync_n), 32'd1);
        chk("rst_ldac_n", 32'(dac_ldac_n), 32'd1);
        chk("rst_sclk", 32'(dac_sclk), 32'd0);
        chk("rst_din", 32'(dac_din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_last", 32'(last_written), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            enable = vecs[i].en;
            host_wr = vecs[i].hw; host_data = vecs[i].hd;
            scan_upd = vecs[i].su; scan_data = vecs[i].sd;
            tick();
            t_strobe = cyc;
            host_wr = 1'b0; scan_upd = 1'b0;
            if (vecs[i].exp_frame) begin
                wait_done(1, 400);
                repeat (3) tick();
                chk($sformatf("v%0d_frames", i), 32'(starts.size()), 32'd1);
                chk($sformatf("v%0d_start", i), 32'(starts[0]), 32'(t_strobe + 1));
                chk($sformatf("v%0d_data", i), 32'(fr_data[0]), {8'h00, 8'h00, vecs[i].exp_data});
                chk($sformatf("v%0d_bits", i), 32'(fr_bits[0]), 32'd24);
                chk($sformatf("v%0d_synclen", i), 32'(fr_len[0]), 32'(49 * CD));
                chk($sformatf("v%0d_ldaclen", i), 32'(ldac_lens[0]), 32'(LW));
                chk($sformatf("v%0d_donecnt", i), 32'(done_cnt), 32'd1);
                chk($sformatf("v%0d_last", i), 32'(last_written), 32'(vecs[i].exp_data));
            end else begin
                repeat (300) tick();
                chk($sformatf("v%0d_noframe", i), 32'(starts.size()), 32'd0);
                chk($sformatf("v%0d_nodone", i), 32'(done_cnt), 32'd0);
            end
            chk($sformatf("v%0d_drop", i), 32'(drop_count), 32'(vecs[i].exp_drop));
            chk($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
            enable = 1'b1;
        end

        // Overwrite while busy: 1111 is replaced by 2222 before it can be sent.
        do_reset();
        scan_upd = 1'b1; scan_data = 16'h3333; tick(); scan_upd = 1'b0;
        tick();
        chk("ow_busy", 32'(busy), 32'd1);
        repeat (5) tick();
        scan_upd = 1'b1; scan_data = 16'h1111; tick(); scan_upd = 1'b0;
        chk("ow_no_drop_yet", 32'(drop_count), 32'd0);
        repeat (10) tick();
        scan_upd = 1'b1; scan_data = 16'h2222; tick(); scan_upd = 1'b0;
        wait_done(2, 600);
        repeat (3) tick();
        chk("ow_frames", 32'(starts.size()), 32'd2);
        chk("ow_first", 32'(fr_data[0]), 32'h003333);
        chk("ow_second", 32'(fr_data[1]), 32'h002222);
        chk("ow_spacing", 32'(starts[1] - starts[0]), 32'(SPACING));
        chk("ow_drop", 32'(drop_count), 32'd1);
        chk("ow_last", 32'(last_written), 32'h2222);

        // Mid-frame reset with a value also waiting in the pending slot.
        clear_mon();
        scan_upd = 1'b1; scan_data = 16'hABCD; tick(); scan_upd = 1'b0;
        repeat (3) tick();
        scan_upd = 1'b1; scan_data = 16'h7777; tick(); scan_upd = 1'b0;
        k = 0;
        while (nbits < 14 && k < 300) begin tick(); k++; end
        chk("mr_reached_bit10", 32'(nbits >= 14), 32'd1);
        n_before = starts.size();
        d_before = done_cnt;
        sinit = 1'b1; tick(); sinit = 1'b0;
        chk("mr_sync_n", 32'(dac_sync_n), 32'd1);
        chk("mr_sclk", 32'(dac_sclk), 32'd0);
        chk("mr_ldac_n", 32'(dac_ldac_n), 32'd1);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_last", 32'(last_written), 32'd0);
        chk("mr_drop", 32'(drop_count), 32'd0);
        repeat (300) tick();
        chk("mr_no_done", 32'(done_cnt), 32'(d_before));
        chk("mr_pending_cleared", 32'(starts.size()), 32'(n_before));
        chk("mr_no_ldac", 32'(ldac_lens.size()), 32'd0);

        // Continuous updates: back-to-back frames and drop_count saturation.
        do_reset();
        scan_upd = 1'b1;
        for (int j = 0; j < 70000; j++) begin
            scan_data = 16'(j);
            tick();
        end
        scan_upd = 1'b0;
        chk("sat_drop", 32'(drop_count), 32'hFFFF);
        repeat (300) tick();
        chk("sat_drop_held", 32'(drop_count), 32'hFFFF);
        chk("sat_idle", 32'(busy), 32'd0);
        bad_sp = 0;
        for (int j = 1; j < starts.size(); j++)
            if (starts[j] - starts[j-1] != SPACING) bad_sp++;
        chk("sat_spacing", 32'(bad_sp), 32'd0);
        chk("sat_frame_count", 32'(starts.size() >= 680), 32'd1);
        chk("sat_done_count", 32'(done_cnt), 32'(starts.size()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_dac_writer.md
Name: scan_dac_writer

Overview:
- Consumer end of the scan-generator output interface: takes the 16-bit scan value and its `output_upd` strobe, plus a host direct-write path.
- Serializes each accepted value as a 24-bit SPI frame to an external 16-bit DAC (AD5662 style), then pulses LDAC.
- Sits between the scan generator / host register bank and the DAC pins; provides readback of the last value written.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 1..255.
- LDAC_WIDTH, 2: clk cycles `dac_ldac_n` is held low; legal range 1..15.
- CMD_BYTE, 8'h00: 8-bit prefix shifted ahead of data; 8'h00 selects normal power mode.

Ports:
- clk  in  1: system clock.
- sinit  in  1: synchronous active-high reset.
- enable  in  1: when low, new scan updates are ignored.
- scan_data  in  16: scan value.
- scan_upd  in  1: one-cycle strobe, scan_data valid.
- host_data  in  16: host direct-write value.
- host_wr  in  1: one-cycle strobe, host_data valid; not gated by enable.
- dac_sclk  out  1: SPI clock, idles low.
- dac_din  out  1: SPI data, MSB first.
- dac_sync_n  out  1: frame select, active low.
- dac_ldac_n  out  1: load strobe, active low.
- busy  out  1: high from frame load until done.
- done  out  1: one-cycle pulse at frame completion.
- last_written  out  16: data field of the last completed frame.
- drop_count  out  16: saturating count of overwritten pending updates.

Behaviour:
- All outputs are registered.
- Reset values: dac_sclk=0, dac_din=0, dac_sync_n=1, dac_ldac_n=1, busy=0, done=0, last_written=0, drop_count=0, pending empty, state IDLE.
- sinit is asserted mid-frame: all of the above take effect on the next edge. The frame is aborted without an LDAC pulse.
- Pending register (one deep):
  - host_wr captures host_data.
  - Else scan_upd&enable captures scan_data.
  - Capture occurs even when pending is already full; the new value overwrites the old.
  - Each overwrite increments drop_count, saturating at 16'hFFFF.
  - host_wr and scan_upd&enable in the same cycle: host wins, and drop_count increments by 1.
  - Capture in the same cycle IDLE consumes pending: the new value becomes pending, with no drop.
- States:
  - IDLE: pending valid -> load shreg={CMD_BYTE,pending}, clear pending, set sync_n=0, din=shreg[23], busy=1 -> SETUP.
  - SETUP: hold CLK_DIV cycles (sclk=0) -> SHIFT.
  - SHIFT: per bit, sclk=1 for CLK_DIV cycles, then sclk=0 for CLK_DIV cycles. At the end of the low half, shift and present the next bit on din; the DAC samples on the falling edge. After bit 0's low half: sync_n=1, din=0 -> LDAC.
  - LDAC: ldac_n=0 for LDAC_WIDTH cycles, then ldac_n=1, done=1, busy=0, last_written=frame data -> IDLE.
- Timing:
  - Latency: strobe sampled at edge N -> pending at N -> sync_n low at edge N+1.
  - sync_n stays low for exactly 49*CLK_DIV cycles.
  - ldac_n falls 1 cycle after sync_n rises.
  - Frame-to-frame: IDLE may start the next frame in the cycle after done, so the minimum spacing between sync_n falls is 49*CLK_DIV+LDAC_WIDTH+2 cycles.
- enable has no effect on a frame in progress or on an already pending value.
- Bit counter is 5 bits (0..23); the half-period counter is 8 bits.

Decomposition:
- Shared package holds:
  - FRAME_BITS=24 and DATA_BITS=16.
  - The state enum {IDLE,SETUP,SHIFT,LDAC}.
  - DAC command constants (normal, power-down 1k, 100k, tristate).
- One natural sub-module, dac_frame_shifter:
  - Owns shreg, the bit and half-period counters, and sclk/din/sync_n.
  - Interface: start/frame in, frame_end out.
  - The top keeps the pending/arbitration logic, LDAC timing and readback.

Test Plan:
- Single update: CLK_DIV=2, LDAC_WIDTH=2, scan_upd with 16'hA5C3, enable=1 -> sync_n low 98 cycles; 24 bits on falling sclk = 0x00A5C3; ldac_n low 2 cycles; done pulse; last_written=16'hA5C3.
- Overwrite: while busy, scan_upd with 16'h1111 then 16'h2222 -> drop_count=1; next frame carries 16'h2222, and no frame carries 16'h1111.
- Collision: host_wr 16'hBEEF and scan_upd 16'h0001 in the same cycle, idle -> frame carries 16'hBEEF; drop_count=1.
- Enable gating: enable=0 with scan_upd 16'h1234 -> no frame. Then host_wr 16'h5678 with enable=0 -> frame sent with 16'h5678.
- Mid-frame reset: sinit at bit 10 -> next edge sync_n=1, sclk=0, ldac_n=1, busy=0, last_written=0; no done pulse; pending cleared.
- Back-to-back and saturation: continuous scan_upd every cycle for 70000 cycles -> frames at spacing 49*CLK_DIV+LDAC_WIDTH+2; drop_count saturates at 16'hFFFF.
